pipe_ctrl: RTL

- Parametrised pipeline control unit for the 5-stage core; replaces the fixed load-use-only stall controller.
- Takes a per-stage stall-request vector and a flush request with a redirect PC.
- Produces the stall bus, a registered one-cycle flush pulse and new_pc, and a stall-watchdog flag.
- Sits beside IF/ID/EX/MEM/WB; stall and flush fan out to every pipeline register.

---
 rtl/pipe_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush control with stall watchdog
//
// Purpose: turns per-stage stall requests and a redirect request into the
// stall bus, a registered one-cycle flush pulse with its redirect PC, and a
// sticky watchdog flag for stalls that last too long.
// Optional feature macro: PIPE_CTRL_PERF_EN (adds performance counters).
//
// Ports:
//   clk               clock, all state changes on the rising edge
//   rst               synchronous active-low reset
//   stallreq          per-stage stall requests (bit 0 = PC register)
//   flush_req         redirect request, one cycle
//   flush_pc          redirect target, valid with flush_req
//   timeout_clr       clears stall_timeout
//   stall             stall bus, bit k holds pipeline register k
//   stall_en          OR of stall
//   flush             one-cycle flush pulse
//   new_pc            redirect PC while flush=1, else 0
//   stall_timeout     sticky watchdog flag
//   perf_stall_cycles cycles with stall_en=1 (PIPE_CTRL_PERF_EN only)
//   perf_flush_count  number of flush pulses (PIPE_CTRL_PERF_EN only)

module pipe_ctrl #(
   parameter int STAGES  = 6,
   parameter int TIMEOUT = 1024,
   parameter int PC_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [STAGES-1:0] stallreq,
   input  logic              flush_req,
   input  logic [PC_W-1:0]   flush_pc,
   input  logic              timeout_clr,
   output logic [STAGES-1:0] stall,
   output logic              stall_en,
   output logic              flush,
   output logic [PC_W-1:0]   new_pc,
   output logic              stall_timeout
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]       perf_stall_cycles,
   output logic [31:0]       perf_flush_count
`endif
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam logic [15:0] WD_MAX = 16'(TIMEOUT);
   localparam logic [15:0] WD_SET = 16'(TIMEOUT - 1);

   state_t            state;
   state_t            state_nxt;
   logic [STAGES-1:0] stall_map;
   logic [PC_W-1:0]   pc_q;
   logic [15:0]       wd_cnt;

   // A stalled stage must also hold every register upstream of it, so the
   // stall bus is a thermometer up to the highest requesting stage.
   always_comb begin
      stall_map = '0;
      for (int k = 0; k < STAGES; k++) begin
         stall_map[k] = |(stallreq >> k);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      flush     = 1'b0;
      new_pc    = '0;
      case (state)
         RUN: begin
            if (flush_req) begin
               state_nxt = FLUSH;
            end else if (|stallreq) begin
               state_nxt = STALL;
            end
         end
         STALL: begin
            if (flush_req) begin
               state_nxt = FLUSH;
            end else if (!(|stallreq)) begin
               state_nxt = RUN;
            end
         end
         FLUSH: begin
            flush  = 1'b1;
            new_pc = pc_q;
            if (flush_req) begin
               state_nxt = FLUSH;
            end else if (|stallreq) begin
               state_nxt = STALL;
            end else begin
               state_nxt = RUN;
            end
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   // The redirect must not be held back, so stall drops during FLUSH.
   assign stall    = (rst && (state != FLUSH)) ? stall_map : '0;
   assign stall_en = |stall;

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q <= '0;
      end else if (flush_req) begin
         pc_q <= flush_pc;
      end
   end

   // Watchdog: counts consecutive stalled cycles; the flag sets on the edge
   // that completes the TIMEOUT-th such cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wd_cnt        <= '0;
         stall_timeout <= 1'b0;
      end else begin
         if (!stall_en || (state == FLUSH)) begin
            wd_cnt <= '0;
         end else if (wd_cnt != WD_MAX) begin
            wd_cnt <= wd_cnt + 16'd1;
         end

         if (timeout_clr) begin
            stall_timeout <= 1'b0;
         end else if (stall_en && (state != FLUSH) && (wd_cnt == WD_SET)) begin
            stall_timeout <= 1'b1;
         end
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_stall_cycles <= '0;
         perf_flush_count  <= '0;
      end else begin
         if (stall_en) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         end
         if (flush) begin
            perf_flush_count <= perf_flush_count + 32'd1;
         end
      end
   end
`endif

endmodule
